muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It consumes the two forwarded 32-bit operands produced by the EX-stage operand-select muxes and executes MULT, MULTU, DIV and DIVU over 33 clock cycles. Results go into architectural HI/LO registers. A `busy` flag tells the hazard unit to stall any dependent MFHI/MFLO or a new mul/div.

## Interface
- `ITER`, 32: number of iteration cycles. Fixed at 32 for 32-bit operands. Present only for documentation; not to be overridden.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  launch operation; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a`  in  32  forwarded rs operand (dividend / multiplicand)
- `b`  in  32  forwarded rt operand (divisor / multiplier)
- `flush`  in  1  abort in-flight operation (exception / branch squash)
- `mthi`  in  1  write `wdata` to HI
- `mtlo`  in  1  write `wdata` to LO
- `wdata`  in  32  MTHI/MTLO data
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse when HI/LO are updated by an operation

## Operation
- **Reset.** One clock; reset is asynchronous and active-low. While `rst_n`=0: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, internal counter=0.
- **States:** IDLE, CALC, FIX.
- **IDLE**
  - If `start`=1 and `flush`=0, latch the operands and enter CALC.
  - For signed ops (MULT, DIV), latch magnitudes |a| and |b|, and record `neg_q` = a[31]^b[31] and `neg_r` = a[31].
  - For unsigned ops, latch a and b as-is with both sign flags 0.
  - Counter is set to 0 on entry to CALC.
- **CALC**
  - One iteration per cycle. Counter increments each cycle; after the 32nd iteration (counter==31), go to FIX.
  - Multiply: shift-add on a 64-bit accumulator with the multiplier in the low half. If acc[0]=1, add the multiplicand to acc[63:32] (33-bit carry kept); then shift right 1.
  - Divide: restoring. Shift {rem, quot} left 1. If rem ≥ divisor, subtract the divisor and set quot[0]=1.
- **FIX:** apply signs and write HI/LO, set `done`=1, return to IDLE.
  - Multiply: if `neg_q`, negate the 64-bit product (two's complement). Then {hi, lo} = product.
  - Divide: lo = quotient, negated if `neg_q`; hi = remainder, negated if `neg_r`. The remainder takes the sign of the dividend.
- **Divide by zero (b=0), defined:** lo=0xFFFFFFFF, hi=a (the original, unsigned bit pattern), for both DIV and DIVU.
  - Detected at start and latched. The unit still runs the full 33 cycles so latency is constant.
- **Signed overflow (DIV 0x80000000 / 0xFFFFFFFF):** lo=0x80000000, hi=0. The magnitude datapath produces this naturally; the bench must confirm it.
- **flush**
  - In CALC or FIX: return to IDLE next edge. HI/LO are unchanged, `done` stays 0.
  - In IDLE: `start` is ignored that cycle.
- **start while busy:** ignored. The hazard unit guarantees it does not occur; the unit must not corrupt state if it does.
- **mthi / mtlo**
  - Honoured only in IDLE; ignored in CALC/FIX.
  - If honoured in the same cycle as an accepted `start`, the write takes effect. The later FIX write overwrites it.
- **Width rules:** the multiply accumulator is 65 bits internally (carry). The divide remainder comparison is 33 bits.

## Timing
- Edge E0 samples `start`=1 in IDLE. E1..E32 perform iterations. E33 executes FIX.
- `busy`=1 from after E0 until after E33 (33 cycles). `busy` is registered and equals (state != IDLE).
- `hi`/`lo` take new values at E33. `done`=1 for exactly the cycle between E33 and E34.
- A new `start` is accepted at E34 at the earliest. Back-to-back operations therefore cost 34 cycles each.
- `hi`/`lo` are readable combinationally from registers at every cycle. They hold their old values during CALC.
- Reset asserted mid-operation forces IDLE and zeroes HI/LO immediately, without waiting for a clock edge.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → at E33, hi=0xFFFFFFFF and lo=0xFFFFFFEB. `done` is high for exactly one cycle; `busy` is high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- Boundary divides:
  - DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x64.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Abort, reset and MT behaviour:
  - Preload hi=0x11111111 via mthi. Start MULT 5×5, assert `flush` at E10 → hi is unchanged, `done` never pulses, `busy` drops after E11.
  - Repeat with `rst_n` low at E10 → hi=lo=0 immediately.
  - mtlo during CALC is ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// Fixed 33-cycle latency: 32 shift-add / restoring iterations plus one sign-fix cycle.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;       // mult: {partial product, multiplier}; div: {rem, quot}
  logic [31:0] opa;       // mult: |multiplicand|; div: raw dividend for the b==0 case
  logic [31:0] opb;       // |divisor|
  logic        is_div, neg_q, neg_r, div0;

  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh, rem_diff;
  logic [63:0] acc_step, prod;

  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    mag_b     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    rem_sh    = acc[63:31];
    rem_diff  = rem_sh - {1'b0, opb};

    if (is_div) begin
      // No borrow out of the 33-bit subtract means rem >= divisor.
      if (!rem_diff[32]) acc_step = {rem_diff[31:0], acc[30:0], 1'b1};
      else               acc_step = {rem_sh[31:0],   acc[30:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[31:1]};
    end

    prod = neg_q ? (~acc + 64'd1) : acc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = CALC;
      CALC: if (flush) state_nxt = IDLE;
            else if (cnt == 5'(ITER - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      opa    <= 32'd0;
      opb    <= 32'd0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= wdata;
          if (mtlo) lo <= wdata;
          if (start && !flush) begin
            cnt    <= 5'd0;
            is_div <= op[1];
            neg_q  <= signed_op & (a[31] ^ b[31]);
            neg_r  <= signed_op & a[31];
            div0   <= (b == 32'd0);
            opa    <= op[1] ? a : mag_a;
            opb    <= mag_b;
            acc    <= {32'd0, op[1] ? mag_a : mag_b};
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          acc <= acc_step;
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod;
            end else if (div0) begin
              hi <= opa;
              lo <= 32'hFFFF_FFFF;
            end else begin
              lo <= neg_q ? (~acc[31:0] + 32'd1)  : acc[31:0];
              hi <= neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic results, latency,
// divide-by-zero / overflow corners, flush, async reset and MT write gating.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk); #1;            // E0 has sampled start
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit poke_lo, input logic [31:0] prev_lo);
    int cyc;
    int busy_cnt;
    launch(o, va, vb);
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cnt++;
      if (poke_lo && cyc == 5) begin
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      end else if (poke_lo && cyc == 6) begin
        check({name, "_mtlo_ignored"}, {32'd0, lo}, {32'd0, prev_lo});
        mtlo = 1'b0;
      end
    end
    check({name, "_latency"}, 64'(cyc), 64'd33);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, "_busy_after"}, {63'd0, busy}, 64'd0);
    check({name, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
    @(posedge clk); #1;
    check({name, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int d0;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    #12;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;

    run_op("mult_neg3x7",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run_op("mult_m1xm1",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
    run_op("div_neg7by2",  2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op("divu_by0",     2'b11, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 0, 0);
    run_op("div_by0_neg",  2'b10, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);

    // MTHI in IDLE, then flush an in-flight MULT
    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h1111_1111;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_idle", {32'd0, hi}, 64'h1111_1111);
    d0 = done_cnt;
    launch(2'b00, 32'd5, 32'd5);
    repeat (10) @(posedge clk);    // E10
    #1 flush = 1'b1;
    @(posedge clk); #1;            // E11
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h1111_1111);
    repeat (40) @(posedge clk);
    #1 check("flush_no_done", 64'(done_cnt - d0), 64'd0);

    // Asynchronous reset mid-operation
    launch(2'b00, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // MTLO during CALC is ignored; lo is still 0 from the reset above
    run_op("divu_100by7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
